// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer and the decoder.
package fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    PRESENT = 2'd3
  } fetch_state_e;

  // Jump mask extremes: all bits sequential, or all bits taken from the target.
  localparam logic [7:0] JUMP_NONE = 8'h00;
  localparam logic [7:0] JUMP_ALL  = 8'hFF;

  // Opcodes (instr[7:4]) shared with the decoder.
  localparam logic [3:0] OP_J   = 4'b1000;
  localparam logic [3:0] OP_JAL = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_BNE = 4'b1101;

endpackage

// File: rtl/pc_next_sel.sv
// Masked next-PC merge and link address. Purely combinational, so the decoder
// bench can reuse it as a reference.
module pc_next_sel #(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] link_pc
);

  logic [ADDR_W-1:0] mask;

  // Each set mask bit takes the target bit; each clear bit takes the sequential bit.
  assign mask    = ADDR_W'(jump);
  assign link_pc = pc + ADDR_W'(1);
  assign next_pc = (link_pc & ~mask) | (jump_target & mask);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: one outstanding memory read, handshake to the
// decoder, masked next-PC update on acceptance, sticky memory-timeout flag.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int          INSTR_W  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int          TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic [7:0]         jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [ADDR_W-1:0]  link_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  next_pc;
  logic [INSTR_W-1:0] instr_q;
  logic               imem_req_q;
  logic               fetch_err_q;
  logic [7:0]         wait_cnt;
  logic               accept;
  logic               timeout;

  pc_next_sel #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_sel (
    .pc          (pc_q),
    .jump        (jump),
    .jump_target (jump_target),
    .next_pc     (next_pc),
    .link_pc     (link_pc)
  );

  // Next-state decode; flags acceptance and timeout for the datapath.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_d = state_q;
    accept  = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      IDLE:    if (run) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT: begin
        // A response on the final counted cycle wins over the timeout.
        if (imem_valid) begin
          state_d = PRESENT;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          state_d = IDLE;
          timeout = 1'b1;
        end
      end
      PRESENT: begin
        if (instr_ready) begin
          accept  = 1'b1;
          state_d = run ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC, instruction latch, request, error flag and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      imem_req_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      state_q    <= state_d;
      imem_req_q <= (state_d == REQ);
      if (state_q == WAIT && imem_valid) instr_q <= imem_rdata;
      if (accept) pc_q <= next_pc;
      if (timeout) fetch_err_q <= 1'b1;
      // Count is 1 in the first WAIT cycle, so it equals TIMEOUT on the last allowed one.
      if (state_q == REQ) begin
        wait_cnt <= 8'd1;
      end else if (state_q == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == PRESENT);
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized fetches
// checked against a transaction-level model of PC, instruction and error flag.
module tb_instruction_fetch;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid;
  logic [7:0] imem_rdata;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] jump;
  logic [7:0] jump_target;
  logic [7:0] link_pc;
  logic [7:0] pc;
  logic       fetch_err;

  instruction_fetch #(
    .ADDR_W   (8),
    .INSTR_W  (8),
    .RESET_PC (8'h00),
    .TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .jump_target (jump_target),
    .link_pc     (link_pc),
    .pc          (pc),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int req_cycle_last = 0;
  int req_cycle_prev = 0;

  // Reference model state.
  logic [7:0] m_pc;
  logic       m_err;
  logic [7:0] m_instr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Next PC from the jump-mask rule, bit by bit.
  function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [7:0] m,
                                            input logic [7:0] t);
    logic [7:0] seq;
    logic [7:0] r;
    seq = cur + 8'd1;
    for (int i = 0; i < 8; i++) r[i] = m[i] ? t[i] : seq[i];
    return r;
  endfunction

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("req_seen", imem_req, 1);
    check("imem_addr", imem_addr, m_pc);
    req_cycle_prev = req_cycle_last;
    req_cycle_last = cycle;
  endtask

  // One complete fetch: memory answers in WAIT cycle `delay`, decoder stalls
  // `holds` cycles, then accepts with the given jump mask/target.
  task automatic fetch(input int delay, input int holds, input logic [7:0] jm,
                       input logic [7:0] jt, input logic run_after, input logic [7:0] data);
    logic [7:0] exp_link;
    run = 1'b1;
    wait_req();
    for (int k = 1; k <= delay; k++) begin
      step();
      if (k == 1) check("req_one_cycle", imem_req, 0);
      check("no_valid_in_wait", instr_valid, 0);
      if (k == delay) begin
        imem_valid = 1'b1;
        imem_rdata = data;
      end
    end
    step();
    imem_valid = 1'b0;
    imem_rdata = 8'($urandom);
    m_instr    = data;
    exp_link   = m_pc + 8'd1;
    check("instr_valid", instr_valid, 1);
    check("instr", instr, m_instr);
    check("link_pc", link_pc, exp_link);
    for (int h = 0; h < holds; h++) begin
      instr_ready = 1'b0;
      jump        = 8'($urandom);
      jump_target = 8'($urandom);
      step();
      check("hold_valid", instr_valid, 1);
      check("hold_instr", instr, m_instr);
      check("hold_pc", pc, m_pc);
    end
    instr_ready = 1'b1;
    jump        = jm;
    jump_target = jt;
    run         = run_after;
    step();
    instr_ready = 1'b0;
    jump        = 8'($urandom);
    jump_target = 8'($urandom);
    m_pc        = model_next(m_pc, jm, jt);
    check("pc_after_accept", pc, m_pc);
    check("instr_kept", instr, m_instr);
    check("valid_dropped", instr_valid, 0);
    check("err_flag", fetch_err, m_err);
    check("req_after_accept", imem_req, run_after);
  endtask

  // Memory stays silent, or answers only on the last allowed WAIT cycle.
  task automatic timeout_fetch(input bit valid_last, input logic [7:0] data);
    run = 1'b1;
    wait_req();
    run = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      step();
      check("tmo_err_low", fetch_err, m_err);
      check("tmo_no_valid", instr_valid, 0);
      if (valid_last && k == TMO) begin
        imem_valid = 1'b1;
        imem_rdata = data;
      end
    end
    step();
    imem_valid = 1'b0;
    if (valid_last) begin
      m_instr = data;
      check("last_cycle_valid", instr_valid, 1);
      check("last_cycle_instr", instr, m_instr);
      check("last_cycle_no_err", fetch_err, m_err);
      instr_ready = 1'b1;
      jump        = 8'h00;
      step();
      instr_ready = 1'b0;
      m_pc = model_next(m_pc, 8'h00, 8'h00);
      check("last_cycle_pc", pc, m_pc);
      check("last_cycle_idle", imem_req, 0);
    end else begin
      m_err = 1'b1;
      check("tmo_err_set", fetch_err, 1);
      check("tmo_idle_valid", instr_valid, 0);
      check("tmo_idle_req", imem_req, 0);
      check("tmo_pc_kept", pc, m_pc);
      imem_valid = 1'b1;
      imem_rdata = 8'h5A;
      step();
      imem_valid = 1'b0;
      check("late_valid_ignored", instr_valid, 0);
      check("late_instr_kept", instr, m_instr);
      step();
      check("late_still_idle", imem_req, 0);
      check("late_still_novalid", instr_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] sel;
    logic [7:0] jm;
    logic       ra;
    rst_n = 1'b0; run = 1'b0; imem_valid = 1'b0; imem_rdata = 8'h00;
    instr_ready = 1'b0; jump = 8'h00; jump_target = 8'h00;
    m_pc = 8'h00; m_err = 1'b0; m_instr = 8'h00;
    #12;
    rst_n = 1'b1;
    check("rst_pc", pc, 8'h00);
    check("rst_req", imem_req, 0);
    check("rst_instr", instr, 8'h00);
    check("rst_valid", instr_valid, 0);
    check("rst_err", fetch_err, 0);
    check("rst_link", link_pc, 8'h01);

    // Sequential run; memory registers the request and answers a cycle later.
    fetch(2, 0, 8'h00, 8'h00, 1'b1, 8'hA1);
    fetch(2, 0, 8'h00, 8'h00, 1'b1, 8'hB2);
    check("req_gap_1", req_cycle_last - req_cycle_prev, 4);
    fetch(2, 0, 8'h00, 8'h00, 1'b1, 8'hC3);
    check("req_gap_2", req_cycle_last - req_cycle_prev, 4);
    fetch(2, 0, 8'h00, 8'h00, 1'b1, 8'h11);
    fetch(2, 0, 8'h00, 8'h00, 1'b1, 8'h22);
    // Full redirect at pc 05.
    check("pc_is_05", pc, 8'h05);
    check("link_05", link_pc, 8'h06);
    fetch(1, 0, 8'hFF, 8'h40, 1'b1, 8'h8D);
    check("redirect_40", pc, 8'h40);
    fetch(1, 0, 8'hFF, 8'h10, 1'b1, 8'h90);
    // Partial mask merges bit by bit.
    fetch(1, 0, 8'h0F, 8'hA3, 1'b1, 8'hC1);
    check("partial_13", pc, 8'h13);
    // Decoder stalls five cycles, accepts on the sixth.
    fetch(1, 5, 8'h00, 8'h00, 1'b1, 8'h33);
    check("stall_14", pc, 8'h14);
    // Wrap from FF.
    fetch(1, 0, 8'hFF, 8'hFF, 1'b1, 8'h44);
    fetch(3, 0, 8'h00, 8'h00, 1'b1, 8'h55);
    check("wrap_00", pc, 8'h00);

    // Randomized fetches.
    for (int i = 0; i < 40; i++) begin
      sel = 3'($urandom_range(0, 4));
      jm  = (sel == 0) ? 8'hFF : (sel == 1) ? 8'($urandom) : 8'h00;
      ra  = ($urandom_range(0, 3) != 0);
      fetch($urandom_range(1, TMO), $urandom_range(0, 3), jm, 8'($urandom), ra,
            8'($urandom));
      if (!ra) begin
        step();
        check("rand_idle", imem_req, 0);
      end
    end

    // Timeout boundary: response on the last cycle wins, silence raises the error.
    timeout_fetch(1'b1, 8'h77);
    timeout_fetch(1'b0, 8'h00);
    // Error is sticky and fetch retries from the same pc.
    fetch(1, 0, 8'h00, 8'h00, 1'b1, 8'h66);
    check("err_sticky", fetch_err, 1);

    // Asynchronous reset while waiting on memory.
    run = 1'b1;
    wait_req();
    step();
    step();
    #2;
    rst_n      = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 8'hEE;
    #1;
    check("async_pc", pc, 8'h00);
    check("async_addr", imem_addr, 8'h00);
    check("async_req", imem_req, 0);
    check("async_instr", instr, 8'h00);
    check("async_valid", instr_valid, 0);
    check("async_err", fetch_err, 0);
    run = 1'b0;
    step();
    imem_valid = 1'b0;
    rst_n      = 1'b1;
    m_pc = 8'h00; m_err = 1'b0; m_instr = 8'h00;
    step();
    check("post_rst_valid", instr_valid, 0);
    check("post_rst_req", imem_req, 0);
    fetch(1, 0, 8'h00, 8'h00, 1'b0, 8'h9C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
